// File: rtl/uart_out_word_serializer.sv
// rtl/uart_out_word_serializer.sv - buffers result words in a FIFO and sends them byte by byte over the rts/rtr UART handshake
//
// Ports:
//   clk             rising-edge system clock
//   rst             synchronous active-low reset
//   word_in         word to transmit (WORD_WIDTH bits)
//   word_valid      word_in is valid; pushed when word_ready is also high
//   word_ready      FIFO has room for a word
//   uart_to_sop_rtr UART ready to receive a byte (only looked at while requesting)
//   uart_to_sop_rts serializer is requesting to send a byte
//   byte_sent       uart_byte_out is valid (held for HOLD_CYCLES cycles)
//   uart_byte_out   byte presented to the UART
//   word_done       one-cycle pulse when the last byte of a word completes
//   fifo_count      number of words held in the FIFO
//   busy            FSM active or words pending

module uart_out_word_serializer #(
    parameter int WORD_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int MSB_FIRST   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WORD_WIDTH-1:0]        word_in,
    input  logic                         word_valid,
    output logic                         word_ready,
    input  logic                         uart_to_sop_rtr,
    output logic                         uart_to_sop_rts,
    output logic                         byte_sent,
    output logic [7:0]                   uart_byte_out,
    output logic                         word_done,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         busy
);

    localparam int BYTES = WORD_WIDTH / 8;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_SEND
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;

    logic [WORD_WIDTH-1:0] word_reg;
    logic [IW-1:0]         byte_idx;
    logic [IW-1:0]         sel;
    logic [HW-1:0]         hold_cnt;
    logic                  last_hold;
    logic                  last_byte;
    logic                  done_evt;
    logic [7:0]            cur_byte;

    // ---------------------------------------------------------------
    // Word FIFO. Pointers are PW bits wide so they wrap on their own.
    // ---------------------------------------------------------------
    assign word_ready = (fifo_count != CW'(DEPTH));
    assign push       = word_valid && word_ready;
    assign pop        = (state == S_LOAD);
    assign busy       = (state != S_IDLE) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Byte selection: byte_idx counts transmission order, sel maps it
    // to the physical byte lane of the latched word.
    // ---------------------------------------------------------------
    assign sel       = (MSB_FIRST != 0) ? (IW'(BYTES - 1) - byte_idx) : byte_idx;
    assign cur_byte  = word_reg[{sel, 3'b000} +: 8];
    assign last_hold = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign last_byte = (byte_idx == IW'(BYTES - 1));
    assign done_evt  = (state == S_SEND) && last_hold && last_byte;

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (fifo_count != '0) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (uart_to_sop_rtr) begin
                    state_nx = S_SEND;
                end
            end
            S_SEND: begin
                if (last_hold) begin
                    if (!last_byte) begin
                        state_nx = S_WAIT;
                    end else if (fifo_count != '0) begin
                        // Next word already queued: go straight to LOAD.
                        state_nx = S_LOAD;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // State, datapath and registered outputs. Outputs are derived from
    // state_nx so they match the state being entered at this edge.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            word_reg        <= '0;
            byte_idx        <= '0;
            hold_cnt        <= '0;
            uart_to_sop_rts <= 1'b0;
            byte_sent       <= 1'b0;
            uart_byte_out   <= 8'h00;
            word_done       <= 1'b0;
        end else begin
            state           <= state_nx;
            uart_to_sop_rts <= (state_nx == S_WAIT);
            byte_sent       <= (state_nx == S_SEND);
            uart_byte_out   <= (state_nx == S_SEND) ? cur_byte : 8'h00;
            word_done       <= done_evt;

            if (state == S_LOAD) begin
                word_reg <= mem[rd_ptr];
                byte_idx <= '0;
            end else if ((state == S_SEND) && last_hold && !last_byte) begin
                byte_idx <= byte_idx + 1'b1;
            end

            if ((state == S_SEND) && !last_hold) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_out_word_serializer.sv
// tb/tb_uart_out_word_serializer.sv - directed self-checking bench for uart_out_word_serializer

module tb_uart_out_word_serializer;

    logic        clk;
    logic        rst;
    logic [31:0] win   [3];
    logic        valid [3];
    logic        rtr   [3];
    logic        ready [3];
    logic        rts   [3];
    logic        sent  [3];
    logic        done  [3];
    logic        busy  [3];
    logic [7:0]  bo    [3];
    logic [2:0]  cnt   [3];

    int n_chk  = 0;
    int n_pass = 0;

    // dut0: defaults, dut1: MSB first, dut2: 16-bit words, 1-cycle hold
    uart_out_word_serializer #(.WORD_WIDTH(32), .DEPTH(4), .HOLD_CYCLES(2), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .word_in(win[0]), .word_valid(valid[0]), .word_ready(ready[0]),
        .uart_to_sop_rtr(rtr[0]), .uart_to_sop_rts(rts[0]), .byte_sent(sent[0]),
        .uart_byte_out(bo[0]), .word_done(done[0]), .fifo_count(cnt[0]), .busy(busy[0]));

    uart_out_word_serializer #(.WORD_WIDTH(32), .DEPTH(4), .HOLD_CYCLES(2), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .word_in(win[1]), .word_valid(valid[1]), .word_ready(ready[1]),
        .uart_to_sop_rtr(rtr[1]), .uart_to_sop_rts(rts[1]), .byte_sent(sent[1]),
        .uart_byte_out(bo[1]), .word_done(done[1]), .fifo_count(cnt[1]), .busy(busy[1]));

    uart_out_word_serializer #(.WORD_WIDTH(16), .DEPTH(4), .HOLD_CYCLES(1), .MSB_FIRST(0)) dut2 (
        .clk(clk), .rst(rst), .word_in(win[2][15:0]), .word_valid(valid[2]), .word_ready(ready[2]),
        .uart_to_sop_rtr(rtr[2]), .uart_to_sop_rts(rts[2]), .byte_sent(sent[2]),
        .uart_byte_out(bo[2]), .word_done(done[2]), .fifo_count(cnt[2]), .busy(busy[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte monitor: logs each byte at its first byte_sent cycle and counts protocol anomalies.
    logic       sent_q   [3] = '{0, 0, 0};
    logic       rts_q    [3] = '{0, 0, 0};
    logic [7:0] bo_q     [3] = '{0, 0, 0};
    int         run      [3] = '{0, 0, 0};
    int         nb       [3] = '{0, 0, 0};
    int         ndone    [3] = '{0, 0, 0};
    int         rtsbad   [3] = '{0, 0, 0};
    int         badrun   [3] = '{0, 0, 0};
    int         unstable [3] = '{0, 0, 0};
    int         overlap  [3] = '{0, 0, 0};
    int         rts_drop [3] = '{0, 0, 0};
    logic [7:0] blog     [3][64];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            sent_q[d] <= sent[d];
            rts_q[d]  <= rts[d];
            bo_q[d]   <= bo[d];
            run[d]    <= sent[d] ? run[d] + 1 : 0;
            if (sent[d] && !sent_q[d]) begin
                if (nb[d] < 64) blog[d][nb[d]] <= bo[d];
                nb[d] <= nb[d] + 1;
                if (!rts_q[d]) rtsbad[d] <= rtsbad[d] + 1;
            end
            if (!sent[d] && sent_q[d] && run[d] != ((d == 2) ? 1 : 2)) badrun[d] <= badrun[d] + 1;
            if (sent[d] && sent_q[d] && bo[d] != bo_q[d]) unstable[d] <= unstable[d] + 1;
            if (sent[d] && rts[d]) overlap[d] <= overlap[d] + 1;
            if (rts_q[d] && !rts[d] && !sent[d]) rts_drop[d] <= rts_drop[d] + 1;
            if (done[d]) ndone[d] <= ndone[d] + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input int d, input logic [31:0] w, output bit ok);
        ok = 0;
        win[d] = w;
        valid[d] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (ready[d]) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (busy[d] === 1'b0) begin
                ok = 1;
                break;
            end
        end
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rts(input int d, output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (rts[d] === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (rts[0] !== 1'b0) $display("FAIL reset_rts: got %b expected 0", rts[0]); else n_pass++;
        n_chk++; if (sent[0] !== 1'b0) $display("FAIL reset_byte_sent: got %b expected 0", sent[0]); else n_pass++;
        n_chk++; if (bo[0] !== 8'h00) $display("FAIL reset_byte_out: got %h expected 00", bo[0]); else n_pass++;
        n_chk++; if (done[0] !== 1'b0) $display("FAIL reset_word_done: got %b expected 0", done[0]); else n_pass++;
        n_chk++; if (cnt[0] !== 3'd0) $display("FAIL reset_fifo_count: got %0d expected 0", cnt[0]); else n_pass++;
        n_chk++; if ({ready[0], ready[1], ready[2]} !== 3'b111) $display("FAIL reset_word_ready: got %b%b%b expected 111", ready[0], ready[1], ready[2]); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (busy[0] !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy[0]); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lsb_first();
        bit ok;
        int b0, d0;
        logic [7:0] exp [4];
        exp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        b0 = nb[0];
        d0 = ndone[0];
        rtr[0] = 1'b1;
        push(0, 32'hA1B2C3D4, ok);
        n_chk++; if (!ok) $display("FAIL lsb_push: got timeout expected accept"); else n_pass++;
        @(negedge clk);
        n_chk++; if (cnt[0] !== 3'd1) $display("FAIL lsb_count_after_push: got %0d expected 1", cnt[0]); else n_pass++;
        n_chk++; if (rts[0] !== 1'b0) $display("FAIL lsb_rts_idle: got %b expected 0", rts[0]); else n_pass++;
        @(negedge clk);
        n_chk++; if (cnt[0] !== 3'd1 || busy[0] !== 1'b1 || rts[0] !== 1'b0) $display("FAIL lsb_load_cycle: got cnt=%0d busy=%b rts=%b expected 1 1 0", cnt[0], busy[0], rts[0]); else n_pass++;
        @(negedge clk);
        n_chk++; if (rts[0] !== 1'b1 || cnt[0] !== 3'd0) $display("FAIL lsb_wait_cycle: got rts=%b cnt=%0d expected 1 0", rts[0], cnt[0]); else n_pass++;
        @(negedge clk);
        n_chk++; if (sent[0] !== 1'b1 || bo[0] !== 8'hD4) $display("FAIL lsb_first_byte: got sent=%b byte=%h expected 1 d4", sent[0], bo[0]); else n_pass++;
        wait_idle(0, ok);
        n_chk++; if (!ok) $display("FAIL lsb_idle: got timeout expected idle"); else n_pass++;
        n_chk++; if (nb[0] - b0 != 4) $display("FAIL lsb_byte_count: got %0d expected 4", nb[0] - b0); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (blog[0][b0 + k] !== exp[k]) $display("FAIL lsb_byte%0d: got %h expected %h", k, blog[0][b0 + k], exp[k]); else n_pass++;
        end
        n_chk++; if (ndone[0] - d0 != 1) $display("FAIL lsb_word_done: got %0d expected 1", ndone[0] - d0); else n_pass++;
        n_chk++; if (rtsbad[0] != 0 || badrun[0] != 0) $display("FAIL lsb_handshake: got rts_missing=%0d bad_hold=%0d expected 0 0", rtsbad[0], badrun[0]); else n_pass++;
    endtask

    task automatic test_msb_first();
        bit ok;
        int b0, d0;
        logic [7:0] exp [4];
        exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        b0 = nb[1];
        d0 = ndone[1];
        rtr[1] = 1'b1;
        push(1, 32'hA1B2C3D4, ok);
        wait_idle(1, ok);
        n_chk++; if (!ok) $display("FAIL msb_idle: got timeout expected idle"); else n_pass++;
        n_chk++; if (nb[1] - b0 != 4) $display("FAIL msb_byte_count: got %0d expected 4", nb[1] - b0); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (blog[1][b0 + k] !== exp[k]) $display("FAIL msb_byte%0d: got %h expected %h", k, blog[1][b0 + k], exp[k]); else n_pass++;
        end
        n_chk++; if (ndone[1] - d0 != 1) $display("FAIL msb_word_done: got %0d expected 1", ndone[1] - d0); else n_pass++;
    endtask

    task automatic test_fifo_full();
        bit ok;
        int b0, nok, errs;
        logic [31:0] w [6];
        logic [7:0] eb;
        for (int i = 0; i < 6; i++) w[i] = 32'h10203040 + i * 32'h01010101;
        b0 = nb[0];
        rtr[0] = 1'b0;
        nok = 0;
        for (int i = 0; i < 5; i++) begin
            push(0, w[i], ok);
            if (ok) nok++;
        end
        n_chk++; if (nok != 5) $display("FAIL full_accepts: got %0d expected 5", nok); else n_pass++;
        @(negedge clk);
        n_chk++; if (cnt[0] !== 3'd4 || ready[0] !== 1'b0) $display("FAIL full_state: got cnt=%0d ready=%b expected 4 0", cnt[0], ready[0]); else n_pass++;
        win[0] = w[5];
        valid[0] = 1'b1;
        errs = 0;
        repeat (20) begin
            @(negedge clk);
            if (ready[0] !== 1'b0 || cnt[0] !== 3'd4 || rts[0] !== 1'b1 || sent[0] !== 1'b0) errs++;
        end
        n_chk++; if (errs != 0) $display("FAIL full_stall: got %0d bad cycles expected 0", errs); else n_pass++;
        n_chk++; if (nb[0] != b0) $display("FAIL full_no_bytes: got %0d expected 0", nb[0] - b0); else n_pass++;
        @(posedge clk);
        #1;
        rtr[0] = 1'b1;
        push(0, w[5], ok);
        n_chk++; if (!ok) $display("FAIL full_sixth_push: got timeout expected accept"); else n_pass++;
        wait_idle(0, ok);
        n_chk++; if (nb[0] - b0 != 24) $display("FAIL full_byte_count: got %0d expected 24", nb[0] - b0); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++) begin
                eb = w[i][8 * k +: 8];
                n_chk++; if (blog[0][b0 + 4 * i + k] !== eb) $display("FAIL full_word%0d_byte%0d: got %h expected %h", i, k, blog[0][b0 + 4 * i + k], eb); else n_pass++;
            end
        end
    endtask

    task automatic test_rtr_delay();
        bit ok;
        int b0, d0, drop0, errs, to;
        logic [7:0] exp [4];
        exp = '{8'h3C, 8'h2D, 8'h1E, 8'h0F};
        b0 = nb[0];
        d0 = ndone[0];
        drop0 = rts_drop[0];
        rtr[0] = 1'b0;
        errs = 0;
        to = 0;
        push(0, 32'h0F1E2D3C, ok);
        for (int k = 0; k < 4; k++) begin
            wait_rts(0, ok);
            if (!ok) to++;
            repeat (10) begin
                @(negedge clk);
                if (rts[0] !== 1'b1 || sent[0] !== 1'b0) errs++;
            end
            @(posedge clk);
            #1;
            rtr[0] = 1'b1;
            @(posedge clk);
            #1;
            // Stray pulse while the byte is being held.
            @(posedge clk);
            #1;
            rtr[0] = 1'b0;
        end
        wait_idle(0, ok);
        n_chk++; if (!ok || to != 0) $display("FAIL delay_timeout: got %0d timeouts expected 0", to); else n_pass++;
        rtr[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rts[0] !== 1'b0 || sent[0] !== 1'b0) errs++;
        end
        rtr[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (errs != 0) $display("FAIL delay_rts_hold: got %0d bad cycles expected 0", errs); else n_pass++;
        n_chk++; if (nb[0] - b0 != 4) $display("FAIL delay_byte_count: got %0d expected 4", nb[0] - b0); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (blog[0][b0 + k] !== exp[k]) $display("FAIL delay_byte%0d: got %h expected %h", k, blog[0][b0 + k], exp[k]); else n_pass++;
        end
        n_chk++; if (rts_drop[0] != drop0) $display("FAIL delay_rts_dropped: got %0d expected 0", rts_drop[0] - drop0); else n_pass++;
        n_chk++; if (ndone[0] - d0 != 1) $display("FAIL delay_word_done: got %0d expected 1", ndone[0] - d0); else n_pass++;
        n_chk++; if (badrun[0] != 0) $display("FAIL delay_hold_len: got %0d bad holds expected 0", badrun[0]); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midword();
        bit ok;
        int b0, b1, d0, errs, to;
        logic [7:0] exp [4];
        exp = '{8'h88, 8'h77, 8'h66, 8'h55};
        b0 = nb[0];
        rtr[0] = 1'b0;
        to = 0;
        push(0, 32'h11223344, ok);
        for (int k = 0; k < 2; k++) begin
            wait_rts(0, ok);
            if (!ok) to++;
            rtr[0] = 1'b1;
            @(posedge clk);
            #1;
            rtr[0] = 1'b0;
        end
        wait_rts(0, ok);
        if (!ok) to++;
        n_chk++; if (to != 0) $display("FAIL rstmid_timeout: got %0d timeouts expected 0", to); else n_pass++;
        n_chk++; if (nb[0] - b0 != 2 || blog[0][b0] !== 8'h44 || blog[0][b0 + 1] !== 8'h33) $display("FAIL rstmid_first_bytes: got n=%0d %h %h expected 2 44 33", nb[0] - b0, blog[0][b0], blog[0][b0 + 1]); else n_pass++;
        d0 = ndone[0];
        b1 = nb[0];
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (rts[0] !== 1'b0 || sent[0] !== 1'b0 || bo[0] !== 8'h00 || done[0] !== 1'b0) $display("FAIL rstmid_outputs: got rts=%b sent=%b byte=%h done=%b expected 0 0 00 0", rts[0], sent[0], bo[0], done[0]); else n_pass++;
        n_chk++; if (cnt[0] !== 3'd0 || ready[0] !== 1'b1 || busy[0] !== 1'b0) $display("FAIL rstmid_fifo: got cnt=%0d ready=%b busy=%b expected 0 1 0", cnt[0], ready[0], busy[0]); else n_pass++;
        rtr[0] = 1'b1;
        errs = 0;
        repeat (30) begin
            @(negedge clk);
            if (sent[0] !== 1'b0 || rts[0] !== 1'b0) errs++;
        end
        n_chk++; if (errs != 0 || nb[0] != b1 || ndone[0] != d0) $display("FAIL rstmid_discard: got bad=%0d bytes=%0d dones=%0d expected 0 0 0", errs, nb[0] - b1, ndone[0] - d0); else n_pass++;
        @(posedge clk);
        #1;
        b1 = nb[0];
        push(0, 32'h55667788, ok);
        wait_idle(0, ok);
        n_chk++; if (nb[0] - b1 != 4) $display("FAIL rstmid_new_count: got %0d expected 4", nb[0] - b1); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (blog[0][b1 + k] !== exp[k]) $display("FAIL rstmid_new_byte%0d: got %h expected %h", k, blog[0][b1 + k], exp[k]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int b0, d0, tdone, trts;
        logic prev_rts;
        logic [7:0] exp [4];
        exp = '{8'hEF, 8'hBE, 8'h34, 8'h12};
        b0 = nb[2];
        d0 = ndone[2];
        rtr[2] = 1'b1;
        push(2, 32'h0000BEEF, ok);
        push(2, 32'h00001234, ok);
        tdone = -1;
        trts = -1;
        prev_rts = rts[2];
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done[2] === 1'b1 && tdone < 0) tdone = i;
            else if (tdone >= 0 && rts[2] === 1'b1 && !prev_rts && trts < 0) trts = i;
            prev_rts = rts[2];
            if (trts >= 0) break;
        end
        n_chk++; if (tdone < 0 || trts - tdone != 1) $display("FAIL b2b_no_idle: got done@%0d rts@%0d expected rts one cycle after done", tdone, trts); else n_pass++;
        wait_idle(2, ok);
        n_chk++; if (nb[2] - b0 != 4) $display("FAIL b2b_byte_count: got %0d expected 4", nb[2] - b0); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (blog[2][b0 + k] !== exp[k]) $display("FAIL b2b_byte%0d: got %h expected %h", k, blog[2][b0 + k], exp[k]); else n_pass++;
        end
        n_chk++; if (ndone[2] - d0 != 2) $display("FAIL b2b_word_done: got %0d expected 2", ndone[2] - d0); else n_pass++;
        n_chk++; if (badrun[2] != 0) $display("FAIL b2b_hold_len: got %0d bad holds expected 0", badrun[2]); else n_pass++;
        n_chk++; if (unstable[0] + unstable[1] + unstable[2] != 0 || overlap[0] + overlap[1] + overlap[2] != 0) $display("FAIL byte_stability: got unstable=%0d overlap=%0d expected 0 0", unstable[0] + unstable[1] + unstable[2], overlap[0] + overlap[1] + overlap[2]); else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            win[d]   = '0;
            valid[d] = 1'b0;
            rtr[d]   = 1'b0;
        end
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_fifo_full();
        test_rtr_delay();
        test_reset_midword();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
